// File: rtl/bwd_pkg.sv
// Shared definitions for the backward input stage: token status codes,
// default field widths and the drain-tracking state encoding.
package bwd_pkg;

  localparam logic [5:0] ST_F_INIT  = 6'b000001;
  localparam logic [5:0] ST_F_RUN   = 6'b000010;
  localparam logic [5:0] ST_F_BREAK = 6'b000100;
  localparam logic [5:0] ST_BCK_INI = 6'b001000;
  localparam logic [5:0] ST_BCK_RUN = 6'b010000;
  localparam logic [5:0] ST_BCK_END = 6'b100000;
  localparam logic [5:0] ST_BUBBLE  = 6'b000000;

  localparam int unsigned READ_NUM_WIDTH_DEF = 8;

  localparam logic [1:0] DRAIN_IDLE = 2'd0;
  localparam logic [1:0] DRAIN_WAIT = 2'd1;
  localparam logic [1:0] DRAIN_DONE = 2'd2;

  function automatic logic is_bubble(input logic [5:0] status);
    return status == ST_BUBBLE;
  endfunction

endpackage

// File: rtl/bwd_skid_fifo.sv
// Small circular buffer holding backward tokens. Push/pop arrive already
// qualified (never push when full, never pop when empty, stall applied).
module bwd_skid_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [WIDTH-1:0]             i_wdata,
  output logic [WIDTH-1:0]             o_rdata,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage write; contents need no reset since reads are gated by count.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/backward_input_stage.sv
// Input stage of the backward pass: filters bubbles from the upstream queue,
// buffers real tokens with one cycle of latency, and reports when the
// stage has drained after the forward pass signals completion.
module backward_input_stage
  import bwd_pkg::*;
#(
  parameter int unsigned READ_NUM_WIDTH = READ_NUM_WIDTH_DEF,
  parameter int unsigned PAYLOAD_W      = 1024,
  parameter int unsigned DEPTH          = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [5:0]                   in_status,
  input  logic [READ_NUM_WIDTH-1:0]    in_read_num,
  input  logic [PAYLOAD_W-1:0]         in_payload,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [5:0]                   out_status,
  output logic [READ_NUM_WIDTH-1:0]    out_read_num,
  output logic [PAYLOAD_W-1:0]         out_payload,
  input  logic                         forward_all_done,
  output logic                         forward_all_done_q,
  output logic                         drained,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [31:0]                  bubble_cnt
);

  localparam int unsigned OCC_W   = $clog2(DEPTH+1);
  localparam int unsigned ENTRY_W = 6 + READ_NUM_WIDTH + PAYLOAD_W;

  logic [OCC_W-1:0]   w_count;
  logic [ENTRY_W-1:0] w_rdata;
  logic               w_accept;
  logic               w_push;
  logic               w_bubble;
  logic               w_pop;
  logic [1:0]         w_drain_nxt;
  logic [1:0]         r_drain;
  logic [31:0]        r_bubble_cnt;
  logic               r_fad_q;

  // Ready depends only on registered occupancy, never on out_ready.
  assign in_ready  = (w_count < OCC_W'(DEPTH));
  assign w_accept  = in_valid && in_ready && !stall;
  assign w_push    = w_accept && !is_bubble(in_status);
  assign w_bubble  = w_accept &&  is_bubble(in_status);
  assign out_valid = (w_count != '0);
  assign w_pop     = out_valid && out_ready && !stall;

  bwd_skid_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({in_status, in_read_num, in_payload}),
    .o_rdata (w_rdata),
    .o_count (w_count)
  );

  assign {out_status, out_read_num, out_payload} = out_valid ? w_rdata : '0;
  assign occupancy          = w_count;
  assign bubble_cnt         = r_bubble_cnt;
  assign forward_all_done_q = r_fad_q;
  assign drained            = (r_drain == DRAIN_DONE);

  // Saturating bubble counter and registered forward-done flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_bubble_cnt <= '0;
      r_fad_q      <= 1'b0;
    end else if (!stall) begin
      r_fad_q <= forward_all_done;
      if (w_bubble && (r_bubble_cnt != '1)) r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  // Drain tracking: a push while DONE re-opens the wait before any idle return.
  always_comb begin
    w_drain_nxt = r_drain;
    case (r_drain)
      DRAIN_IDLE: if (forward_all_done) w_drain_nxt = DRAIN_WAIT;
      DRAIN_WAIT: begin
        if (!forward_all_done)                w_drain_nxt = DRAIN_IDLE;
        else if ((w_count == '0) && !w_push)  w_drain_nxt = DRAIN_DONE;
      end
      DRAIN_DONE: begin
        if (w_push)                 w_drain_nxt = DRAIN_WAIT;
        else if (!forward_all_done) w_drain_nxt = DRAIN_IDLE;
      end
      default:                      w_drain_nxt = DRAIN_IDLE;
    endcase
  end

  // Drain state register.
  always_ff @(posedge clk) begin
    if (!rst)        r_drain <= DRAIN_IDLE;
    else if (!stall) r_drain <= w_drain_nxt;
  end

endmodule

// File: tb/tb_backward_input_stage.sv
// Self-checking bench for backward_input_stage: directed scenarios followed
// by a randomized run, all compared against a queue-based reference model.
module tb_backward_input_stage;
  import bwd_pkg::*;

  localparam int unsigned RNW = 8;
  localparam int unsigned PW  = 64;
  localparam int unsigned D   = 2;
  localparam int unsigned OW  = $clog2(D+1);

  logic           clk = 1'b0;
  logic           rst, stall, in_valid, in_ready, out_valid, out_ready;
  logic [5:0]     in_status, out_status;
  logic [RNW-1:0] in_read_num, out_read_num;
  logic [PW-1:0]  in_payload, out_payload;
  logic           forward_all_done, forward_all_done_q, drained;
  logic [OW-1:0]  occupancy;
  logic [31:0]    bubble_cnt;

  backward_input_stage #(
    .READ_NUM_WIDTH (RNW),
    .PAYLOAD_W      (PW),
    .DEPTH          (D)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .stall              (stall),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_status          (in_status),
    .in_read_num        (in_read_num),
    .in_payload         (in_payload),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_status         (out_status),
    .out_read_num       (out_read_num),
    .out_payload        (out_payload),
    .forward_all_done   (forward_all_done),
    .forward_all_done_q (forward_all_done_q),
    .drained            (drained),
    .occupancy          (occupancy),
    .bubble_cnt         (bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]     st;
    logic [RNW-1:0] rn;
    logic [PW-1:0]  pl;
  } tok_t;

  typedef enum {M_IDLE, M_WAIT, M_DONE} mdrain_t;

  tok_t        m_q[$];
  longint      m_bub;
  bit          m_fadq;
  mdrain_t     m_d = M_IDLE;
  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned n_popped = 0;
  logic [5:0]  st_tab [7];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all();
    tok_t e;
    e = (m_q.size() != 0) ? m_q[0] : '0;
    chk("in_ready",   in_ready,   m_q.size() < D);
    chk("out_valid",  out_valid,  m_q.size() != 0);
    chk("out_status", out_status, e.st);
    chk("out_rn",     out_read_num, e.rn);
    chk("out_pl",     out_payload, e.pl);
    chk("occupancy",  occupancy,  m_q.size());
    chk("bubble_cnt", bubble_cnt, m_bub);
    chk("fad_q",      forward_all_done_q, m_fadq);
    chk("drained",    drained,    m_d == M_DONE);
  endtask

  // One clock: model follows the stage rules using the inputs at the edge.
  task automatic cycle();
    bit ready, push, bub, pop;
    if (out_valid && out_ready && !stall && rst) n_popped++;
    @(posedge clk);
    if (!rst) begin
      m_q.delete();
      m_bub  = 0;
      m_fadq = 1'b0;
      m_d    = M_IDLE;
    end else if (!stall) begin
      ready = m_q.size() < D;
      push  = in_valid && ready && (in_status != ST_BUBBLE);
      bub   = in_valid && ready && (in_status == ST_BUBBLE);
      pop   = (m_q.size() != 0) && out_ready;
      case (m_d)
        M_IDLE: if (forward_all_done) m_d = M_WAIT;
        M_WAIT: if (!forward_all_done) m_d = M_IDLE;
                else if (m_q.size() == 0 && !push) m_d = M_DONE;
        M_DONE: if (push) m_d = M_WAIT;
                else if (!forward_all_done) m_d = M_IDLE;
        default: m_d = M_IDLE;
      endcase
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back('{st: in_status, rn: in_read_num, pl: in_payload});
      if (bub && m_bub < 64'hFFFF_FFFF) m_bub++;
      m_fadq = forward_all_done;
    end
    #1;
    check_all();
  endtask

  task automatic drive(input logic v, input logic [5:0] st, input logic [RNW-1:0] rn,
                       input logic [PW-1:0] pl);
    in_valid    = v;
    in_status   = st;
    in_read_num = rn;
    in_payload  = pl;
  endtask

  function automatic logic [PW-1:0] rnd_pl();
    return {$urandom, $urandom};
  endfunction

  task automatic reset_pulse();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
  endtask

  initial begin
    st_tab = '{ST_F_INIT, ST_F_RUN, ST_F_BREAK, ST_BCK_INI, ST_BCK_RUN, ST_BCK_END, ST_BUBBLE};
    rst = 1'b0; stall = 1'b0; out_ready = 1'b0; forward_all_done = 1'b0;
    drive(1'b0, ST_BUBBLE, '0, '0);

    // Reset state, including reset taking effect while stalled.
    cycle();
    stall = 1'b1;
    drive(1'b1, ST_BCK_RUN, 8'd9, 64'h1);
    cycle();
    stall = 1'b0;
    drive(1'b0, ST_BUBBLE, '0, '0);
    cycle();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_drained",  drained,  1'b0);
    rst = 1'b1;

    // Single token, one cycle latency.
    drive(1'b1, ST_BCK_RUN, 8'd5, 64'hA5);
    cycle();
    chk("t1_valid",  out_valid,    1'b1);
    chk("t1_status", out_status,   6'b010000);
    chk("t1_rn",     out_read_num, 8'd5);
    chk("t1_occ",    occupancy,    1);
    drive(1'b0, ST_BUBBLE, '0, '0);
    out_ready = 1'b1;
    cycle();

    // Fill to full with out_ready low, third token held off.
    out_ready = 1'b0;
    drive(1'b1, ST_BCK_RUN, 8'd1, rnd_pl());
    cycle();
    drive(1'b1, ST_BCK_RUN, 8'd2, rnd_pl());
    cycle();
    chk("full_ready", in_ready, 1'b0);
    drive(1'b1, ST_BCK_RUN, 8'd3, rnd_pl());
    cycle();
    cycle();
    out_ready = 1'b1;
    #1;
    chk("full_no_comb_ready", in_ready, 1'b0);
    chk("order_1", out_read_num, 8'd1);
    cycle();
    chk("order_2", out_read_num, 8'd2);
    cycle();
    chk("order_3", out_read_num, 8'd3);
    drive(1'b0, ST_BUBBLE, '0, '0);
    cycle();

    // Streaming across many pointer wraps.
    for (int unsigned i = 0; i < 100; i++) begin
      drive(1'b1, ST_BCK_RUN, RNW'(i), rnd_pl());
      cycle();
      chk("stream_rn", out_read_num, RNW'(i));
    end
    drive(1'b0, ST_BUBBLE, '0, '0);
    cycle();

    // Bubble filtering with a 4-cycle stall in the middle.
    reset_pulse();
    n_popped = 0;
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 13; i++) begin
      if (i == 6) begin
        stall = 1'b1;
        for (int unsigned s = 0; s < 4; s++) begin
          drive(1'($urandom), st_tab[$urandom_range(0, 6)], RNW'($urandom), rnd_pl());
          forward_all_done = 1'($urandom);
          out_ready = 1'($urandom);
          cycle();
        end
        stall = 1'b0;
        forward_all_done = 1'b0;
        out_ready = 1'b1;
      end
      drive(1'b1, (i % 4 == 1) ? ST_BCK_INI : ST_BUBBLE, RNW'(i), rnd_pl());
      cycle();
    end
    drive(1'b0, ST_BUBBLE, '0, '0);
    cycle();
    cycle();
    chk("bubble_total", bubble_cnt, 32'd10);
    chk("bubble_outs",  n_popped,   3);

    // Drain tracking.
    reset_pulse();
    out_ready = 1'b0;
    drive(1'b1, ST_BCK_END, 8'd40, rnd_pl());
    cycle();
    drive(1'b1, ST_BCK_END, 8'd41, rnd_pl());
    cycle();
    drive(1'b0, ST_BUBBLE, '0, '0);
    forward_all_done = 1'b1;
    cycle();
    cycle();
    chk("drain_wait", drained, 1'b0);
    out_ready = 1'b1;
    cycle();
    cycle();
    chk("drain_last_pop", drained, 1'b0);
    cycle();
    chk("drain_done", drained, 1'b1);
    out_ready = 1'b0;
    drive(1'b1, ST_BCK_RUN, 8'd42, rnd_pl());
    cycle();
    chk("drain_reopen", drained, 1'b0);
    drive(1'b1, ST_BCK_RUN, 8'd43, rnd_pl());
    rst = 1'b0;
    cycle();
    chk("drain_rst_occ", occupancy, 0);
    chk("drain_rst_drained", drained, 1'b0);
    rst = 1'b1;
    forward_all_done = 1'b0;
    drive(1'b0, ST_BUBBLE, '0, '0);
    cycle();

    // Randomized traffic.
    for (int unsigned i = 0; i < 400; i++) begin
      drive(1'($urandom), st_tab[$urandom_range(0, 6)], RNW'($urandom), rnd_pl());
      out_ready = ($urandom_range(0, 3) != 0);
      stall     = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) forward_all_done = ~forward_all_done;
      rst       = ($urandom_range(0, 63) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
